// File: rtl/calc_sequencer.sv
// Multi-cycle arithmetic engine: add/sub/pass in 2 cycles, and mul/div/mod over one
// 32-step shift/add-subtract datapath, with a display range check on the signed result.
module calc_sequencer #(
  parameter int unsigned MAX_POS  = 999_999,
  parameter int unsigned MAX_NEG  = 99_999,
  parameter logic [31:0] ERR_CODE = 32'h00EE_0000
) (
  input  logic        sw_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic [2:0]  operator,
  output logic [31:0] ans,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, DIV, FIX, DONE} state_t;

  localparam logic [2:0] OP_EQU   = 3'd0;
  localparam logic [2:0] OP_TIMES = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_PLUS  = 3'd3;
  localparam logic [2:0] OP_MINUS = 3'd4;
  localparam logic [2:0] OP_MOD   = 3'd5;

  state_t      state, next_state;
  logic [31:0] op1_q, op2_q;
  logic [2:0]  opr_q;
  logic [31:0] mag_b;     // multiplicand (MUL) or divisor (DIV)
  logic [63:0] acc;       // MUL: {partial, multiplier}; DIV: {remainder, quotient}
  logic        neg_q;
  logic        err_q;
  logic [4:0]  cnt;

  logic        load_err, is_divmod;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] raw, raw_abs;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] fix_mag;
  logic        fix_err;
  logic [31:0] fix_val;

  assign busy = (state != IDLE);

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    is_divmod = (opr_q == OP_DIV) || (opr_q == OP_MOD);
    load_err  = (opr_q > OP_MOD) || (is_divmod && (op2_q == 32'd0));
    op1_abs   = op1_q[31] ? -op1_q : op1_q;
    op2_abs   = op2_q[31] ? -op2_q : op2_q;

    raw = {op1_q[31], op1_q};
    case (opr_q)
      OP_PLUS:  raw = {op1_q[31], op1_q} + {op2_q[31], op2_q};
      OP_MINUS: raw = {op1_q[31], op1_q} - {op2_q[31], op2_q};
      default:  raw = {op1_q[31], op1_q};
    endcase
    raw_abs = raw[32] ? -raw : raw;

    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    div_trial = acc[63:31] - {1'b0, mag_b};

    fix_mag = acc;
    case (opr_q)
      OP_DIV:  fix_mag = {32'd0, acc[31:0]};
      OP_MOD:  fix_mag = {32'd0, acc[63:32]};
      default: fix_mag = acc;
    endcase
    // Range check on the magnitude is equivalent to the full-width signed compare.
    fix_err = err_q || (neg_q ? (fix_mag > 64'(MAX_NEG)) : (fix_mag > 64'(MAX_POS)));
    fix_val = neg_q ? -fix_mag[31:0] : fix_mag[31:0];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start && !abort) next_state = LOAD;
      LOAD: begin
        if (abort)                   next_state = IDLE;
        else if (load_err)           next_state = FIX;
        else if (opr_q == OP_TIMES)  next_state = MUL;
        else if (is_divmod)          next_state = DIV;
        else                         next_state = FIX;
      end
      MUL:     next_state = abort ? IDLE : ((cnt == 5'd0) ? FIX : MUL);
      DIV:     next_state = abort ? IDLE : ((cnt == 5'd0) ? FIX : DIV);
      FIX:     next_state = abort ? IDLE : DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sw_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_ff @(posedge sw_clk) begin
    if (!rst) begin
      // NOTE: there are no memory arrays; every register, datapath included, is cleared here.
      op1_q <= '0;
      op2_q <= '0;
      opr_q <= '0;
      mag_b <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
      cnt   <= '0;
      ans   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            op1_q <= operand1;
            op2_q <= operand2;
            opr_q <= operator;
          end
        end
        LOAD: begin
          cnt   <= 5'd31;
          err_q <= load_err;
          case (opr_q)
            OP_TIMES: begin
              neg_q <= op1_q[31] ^ op2_q[31];
              mag_b <= op1_abs;
              acc   <= {32'd0, op2_abs};
            end
            OP_DIV, OP_MOD: begin
              neg_q <= (opr_q == OP_MOD) ? op1_q[31] : (op1_q[31] ^ op2_q[31]);
              mag_b <= op2_abs;
              acc   <= {32'd0, op1_abs};
            end
            default: begin
              neg_q <= raw[32];
              acc   <= {31'd0, raw_abs};
            end
          endcase
        end
        MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt - 5'd1;
        end
        DIV: begin
          // Restoring step: keep the trial remainder only when it did not borrow.
          acc <= div_trial[32] ? {acc[62:0], 1'b0} : {div_trial[31:0], acc[30:0], 1'b1};
          cnt <= cnt - 5'd1;
        end
        FIX: begin
          if (!abort) begin
            ans  <= fix_err ? ERR_CODE : fix_val;
            err  <= fix_err;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer: results, latency, error range,
// capture/ignore rules, abort and mid-operation reset.
module tb_calc_sequencer;

  localparam logic [31:0] ERR = 32'h00EE_0000;
  localparam logic [2:0] EQU = 3'd0, TIMES = 3'd1, DIVI = 3'd2, PLUS = 3'd3, MINUS = 3'd4, MODU = 3'd5;

  logic        sw_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic [2:0]  operator = '0;
  logic [31:0] ans;
  logic        done, busy, err;

  int n_cmp = 0;
  int n_err = 0;

  calc_sequencer dut (
    .sw_clk(sw_clk), .rst(rst), .start(start), .abort(abort),
    .operand1(operand1), .operand2(operand2), .operator(operator),
    .ans(ans), .done(done), .busy(busy), .err(err)
  );

  always #5 sw_clk = ~sw_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulses start across edge 0, then scrambles the inputs to prove they were captured.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge sw_clk);
    operator = op; operand1 = a; operand2 = b; start = 1'b1;
    @(posedge sw_clk); #1;
    start = 1'b0; operand1 = $urandom; operand2 = $urandom; operator = PLUS;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge sw_clk); #1;
      if (done === 1'b1) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [31:0] exp_ans,
                     input logic exp_err);
    int lat;
    launch(op, a, b);
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " ans"}, ans, exp_ans);
    check({tag, " err"}, 32'(err), 32'(exp_err));
    @(posedge sw_clk); #1;
    check({tag, " done cleared"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [31:0] held;

    repeat (2) @(posedge sw_clk);
    #1;
    check("reset ans", ans, 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge sw_clk) rst = 1'b1;

    run("plus max", PLUS, 32'd123456, 32'd876543, 2, 32'd999999, 1'b0);
    run("plus over", PLUS, 32'd999999, 32'd1, 2, ERR, 1'b1);
    run("minus neg", MINUS, 32'd5, 32'd12, 2, -32'sd7, 1'b0);
    run("equ min neg", EQU, -32'sd99999, 32'd0, 2, -32'sd99999, 1'b0);
    run("equ under", EQU, -32'sd100000, 32'd0, 2, ERR, 1'b1);
    run("times neg", TIMES, -32'sd1234, 32'd81, 34, -32'sd99954, 1'b0);
    run("times over", TIMES, 32'd1000, 32'd1000, 34, ERR, 1'b1);
    run("times zero", TIMES, 32'd0, -32'sd5, 34, 32'd0, 1'b0);
    run("times minint", TIMES, 32'h8000_0000, 32'd1, 34, ERR, 1'b1);
    run("div neg", DIVI, -32'sd17, 32'd5, 34, -32'sd3, 1'b0);
    run("mod neg", MODU, -32'sd17, 32'd5, 34, -32'sd2, 1'b0);
    run("div negdiv", DIVI, 32'd17, -32'sd5, 34, -32'sd3, 1'b0);
    run("mod negdiv", MODU, 32'd17, -32'sd5, 34, 32'd2, 1'b0);
    run("div by zero", DIVI, 32'd5, 32'd0, 2, ERR, 1'b1);
    run("mod by zero", MODU, 32'd5, 32'd0, 2, ERR, 1'b1);
    run("illegal op6", 3'd6, 32'd1, 32'd2, 2, ERR, 1'b1);
    run("illegal op7", 3'd7, 32'd1, 32'd2, 2, ERR, 1'b1);

    // A start raised mid-operation must not disturb the running multiply.
    launch(TIMES, 32'd999, -32'sd100);
    repeat (4) @(posedge sw_clk);
    @(negedge sw_clk);
    start = 1'b1; operator = PLUS; operand1 = 32'd1; operand2 = 32'd1;
    @(posedge sw_clk); #1;
    start = 1'b0;
    wait_done(lat);
    check("busy start latency", 32'(lat), 32'd29);
    check("busy start ans", ans, -32'sd99900);
    check("busy start err", 32'(err), 32'd0);

    // A start sampled in DONE is dropped, not queued.
    @(negedge sw_clk);
    start = 1'b1;
    @(posedge sw_clk); #1;
    start = 1'b0;
    @(posedge sw_clk); #1;
    check("done start ignored", 32'(busy), 32'd0);

    held = ans;
    repeat (5) @(posedge sw_clk);
    #1;
    check("ans holds", ans, held);

    // Abort sampled at edge 11 of a multiply.
    launch(TIMES, 32'd7, 32'd6);
    repeat (10) @(posedge sw_clk);
    #1;
    check("abort busy before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(posedge sw_clk); #1;
    abort = 1'b0;
    check("abort busy after", 32'(busy), 32'd0);
    check("abort ans kept", ans, -32'sd99900);
    check("abort err kept", 32'(err), 32'd0);
    seen = 0;
    for (int e = 0; e < 30; e++) begin
      @(posedge sw_clk); #1;
      if (done === 1'b1) seen++;
    end
    check("abort no done", 32'(seen), 32'd0);

    @(negedge sw_clk);
    start = 1'b1; abort = 1'b1; operator = PLUS;
    @(posedge sw_clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort beats start", 32'(busy), 32'd0);

    run("pre reset err", DIVI, 32'd9, 32'd0, 2, ERR, 1'b1);
    launch(DIVI, 32'd100, 32'd7);
    repeat (10) @(posedge sw_clk);
    @(negedge sw_clk) rst = 1'b0;
    @(posedge sw_clk); #1;
    check("midrst ans", ans, 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    @(negedge sw_clk) rst = 1'b1;

    run("div after rst", DIVI, 32'd100, 32'd7, 34, 32'd14, 1'b0);
    run("mod after rst", MODU, 32'd100, 32'd7, 34, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
